// File: rtl/shift_pipe_nbit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL), one register stage per power-of-two shift.
// A single advance enable stalls every stage together, so backpressure is lossless.
module shift_pipe_nbit #(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH),
    parameter  int TAG_W   = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   shift_out,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int         LAST     = SHAMT_W - 1;
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    logic [WIDTH-1:0]   r_data  [SHAMT_W];
    logic [SHAMT_W-1:0] r_shamt [SHAMT_W];
    logic [1:0]         r_mode  [SHAMT_W];
    logic [TAG_W-1:0]   r_tag   [SHAMT_W];
    logic               r_valid [SHAMT_W];

    logic [WIDTH-1:0]   w_data_in      [SHAMT_W];
    logic [WIDTH-1:0]   w_data_shifted [SHAMT_W];
    logic [SHAMT_W-1:0] w_shamt_in     [SHAMT_W];
    logic [1:0]         w_mode_in      [SHAMT_W];
    logic [TAG_W-1:0]   w_tag_in       [SHAMT_W];
    logic               w_valid_in     [SHAMT_W];
    logic               w_adv;

    // Under SRA the MSB of every intermediate value is still the original sign bit,
    // so filling from the current MSB is the same as filling from the operand's MSB.
    function automatic logic [WIDTH-1:0] f_shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int               sh
    );
        logic [WIDTH-1:0] res;
        case (m)
            MODE_SLL: res = d << sh;
            MODE_SRL: res = d >> sh;
            MODE_SRA: res = $signed(d) >>> sh;
            default:  res = (d << sh) | (d >> (WIDTH - sh));
        endcase
        return res;
    endfunction

    assign w_adv     = !r_valid[LAST] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[LAST];
    assign shift_out = r_data[LAST];
    assign out_tag   = r_tag[LAST];

    always_comb begin
        w_data_in[0]  = data_operandA;
        w_shamt_in[0] = ctrl_shiftamt;
        w_mode_in[0]  = ctrl_mode;
        w_tag_in[0]   = in_tag;
        w_valid_in[0] = in_valid;
        for (int k = 1; k < SHAMT_W; k++) begin
            w_data_in[k]  = r_data[k-1];
            w_shamt_in[k] = r_shamt[k-1];
            w_mode_in[k]  = r_mode[k-1];
            w_tag_in[k]   = r_tag[k-1];
            w_valid_in[k] = r_valid[k-1];
        end
        for (int k = 0; k < SHAMT_W; k++) begin
            w_data_shifted[k] = w_shamt_in[k][k] ? f_shift_stage(w_data_in[k], w_mode_in[k], 1 << k)
                                                 : w_data_in[k];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_mode[k]  <= '0;
                r_tag[k]   <= '0;
                r_valid[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                r_data[k]  <= w_data_shifted[k];
                r_shamt[k] <= w_shamt_in[k];
                r_mode[k]  <= w_mode_in[k];
                r_tag[k]   <= w_tag_in[k];
                r_valid[k] <= w_valid_in[k];
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe_nbit.sv
// Scoreboard bench for shift_pipe_nbit: directed vectors push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_shift_pipe_nbit;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   data_operandA = '0;
    logic [SHAMT_W-1:0] ctrl_shiftamt = '0;
    logic [1:0]         ctrl_mode = '0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   shift_out;
    logic [TAG_W-1:0]   out_tag;

    shift_pipe_nbit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .ctrl_mode     (ctrl_mode),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .shift_out     (shift_out),
        .out_tag       (out_tag)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int out_count = 0;
    int run_len  = 0;
    int last_run = 0;
    logic [WIDTH+TAG_W-1:0] exp_q[$];
    logic [WIDTH+TAG_W-1:0] mon_e;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  amt;
        logic [1:0]  m;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17] = '{
        '{32'h8000_00F0, 5'd4,  SRA, 32'hF800_000F},
        '{32'h8000_00F0, 5'd4,  SRL, 32'h0800_000F},
        '{32'h8000_0001, 5'd1,  ROL, 32'h0000_0003},
        '{32'hDEAD_BEEF, 5'd0,  SLL, 32'hDEAD_BEEF},
        '{32'hDEAD_BEEF, 5'd0,  SRL, 32'hDEAD_BEEF},
        '{32'hDEAD_BEEF, 5'd0,  SRA, 32'hDEAD_BEEF},
        '{32'hDEAD_BEEF, 5'd0,  ROL, 32'hDEAD_BEEF},
        '{32'hA5A5_A5A5, 5'd31, SLL, 32'h8000_0000},
        '{32'hA5A5_A5A5, 5'd31, SRL, 32'h0000_0001},
        '{32'hA5A5_A5A5, 5'd31, SRA, 32'hFFFF_FFFF},
        '{32'h5A5A_5A5A, 5'd31, SRA, 32'h0000_0000},
        '{32'hA5A5_A5A5, 5'd31, ROL, 32'hD2D2_D2D2},
        '{32'h1234_5678, 5'd8,  ROL, 32'h3456_7812},
        '{32'h8000_0000, 5'd5,  SRA, 32'hFC00_0000},
        '{32'h0000_00FF, 5'd12, SLL, 32'h000F_F000},
        '{32'hF000_0000, 5'd3,  SRL, 32'h1E00_0000},
        '{32'hF000_000F, 5'd4,  ROL, 32'h0000_00FF}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Monitor: a transfer happens on the next rising edge when out_valid && out_ready.
    initial forever begin
        @(negedge clock);
        #2;
        if (!reset_n) begin
            run_len = 0;
        end else begin
            if (out_valid) run_len++;
            else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                out_count++;
                check("scoreboard_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("result_data", shift_out, mon_e[WIDTH+TAG_W-1:TAG_W]);
                    check("result_tag", 32'(out_tag), 32'(mon_e[TAG_W-1:0]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs are scrambled while the request is blocked; only accepted values may count.
    task automatic send(input logic [31:0] d, input logic [4:0] amt, input logic [1:0] m,
                        input logic [4:0] tag, input logic [31:0] exp);
        int waited = 0;
        @(negedge clock);
        in_valid = 1'b1; data_operandA = d; ctrl_shiftamt = amt; ctrl_mode = m; in_tag = tag;
        #1;
        while (!in_ready && waited < 200) begin
            data_operandA = ~d; ctrl_shiftamt = amt + 5'd3; ctrl_mode = m + 2'd1; in_tag = ~tag;
            @(negedge clock);
            data_operandA = d; ctrl_shiftamt = amt; ctrl_mode = m; in_tag = tag;
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back({d == d ? exp : exp, tag});
            @(posedge clock);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Counts rising edges from the accept edge (inclusive) to out_valid becoming visible.
    task automatic measure_latency(input int exp_edges);
        int edges = 1;
        bit seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
            #2;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock);
            edges++;
        end
        check("latency_edges", seen ? 32'(edges) : 32'hFFFF_FFFF, 32'(exp_edges));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    int cnt_before;
    int ghost;

    initial begin
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_shift_out", shift_out, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        send(32'h0000_0001, 5'd31, SLL, 5'd3, 32'h8000_0000);
        measure_latency(SHAMT_W);
        wait_drain();

        foreach (vecs[i]) send(vecs[i].d, vecs[i].amt, vecs[i].m, 5'(i + 4), vecs[i].exp);
        idle();
        wait_drain();

        for (int i = 0; i < 8; i++) send(32'h1, 5'(i), SLL, 5'(i), 32'h1 << i);
        idle();
        wait_drain();
        check("stream_run_length", 32'(last_run), 32'd8);

        cnt_before = out_count;
        @(negedge clock);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h8000_0000, 5'(i), SRL, 5'(10 + i), 32'h8000_0000 >> i);
                idle();
            end
            begin
                int w = 0;
                while (!out_valid && w < 50) begin
                    @(negedge clock);
                    #3;
                    w++;
                end
                check("stall_out_valid_seen", 32'(out_valid), 32'd1);
                repeat (3) begin
                    @(negedge clock);
                    #3;
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_data_stable", shift_out, 32'h8000_0000);
                    check("stall_tag_stable", 32'(out_tag), 32'd10);
                end
                @(negedge clock);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("backpressure_output_count", 32'(out_count - cnt_before), 32'd6);

        send(32'h0000_0001, 5'd1, SLL, 5'd1, 32'h0000_0002);
        send(32'h0000_0001, 5'd2, SLL, 5'd2, 32'h0000_0004);
        send(32'h0000_0001, 5'd3, SLL, 5'd3, 32'h0000_0008);
        @(negedge clock);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_shift_out", shift_out, 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ghost = 0;
        repeat (8) begin
            @(negedge clock);
            #2;
            if (out_valid) ghost++;
        end
        check("post_reset_no_ghost", 32'(ghost), 32'd0);

        send(32'h0000_0F0F, 5'd4, ROL, 5'd21, 32'h0000_F0F0);
        measure_latency(SHAMT_W);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_pipe_nbit.md
Name: shift_pipe_nbit

Overview:
- Parametrised, pipelined barrel shifter: the successor to the fixed 32-bit combinational left shifter.
- Supports four modes: logical left, logical right, arithmetic right, rotate left.
- One register stage follows each power-of-two shift stage; valid/ready handshake with full backpressure.
- Sits between the ALU issue logic and writeback so the shift path no longer limits cycle time.

Parameters:
- WIDTH, 32, data width; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width and pipeline depth; derived, not to be overridden.
- TAG_W, 5, width of the sideband tag (destination register) carried alongside the data.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts request this cycle.
- data_operandA  input  WIDTH  value to shift.
- ctrl_shiftamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- ctrl_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- shift_out  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Pipeline structure:
  - Stage k (k = 0..SHAMT_W-1) shifts by 2^k when shamt bit k = 1, otherwise passes data through.
  - Each stage registers: data, remaining shamt bits, mode, tag, valid.
  - The last stage register drives shift_out, out_tag and out_valid directly; there is no output combinational logic.
- Fill rules per mode:
  - SLL: zeros fill from the LSB.
  - SRL: zeros fill from the MSB.
  - SRA: the MSB of the original operand fills from the MSB. The sign bit is carried unchanged through every stage.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Latency: exactly SHAMT_W cycles (5 at WIDTH=32) from the accept edge to out_valid, when there is no backpressure.
- Throughput: one request per cycle.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational from out_valid and out_ready).
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - When adv = 0, every stage register holds, including valid bits. shift_out and out_tag stay stable while out_valid = 1 and out_ready = 0.
  - Bubbles: when adv = 1 and in_valid = 0, stage 0 loads valid = 0. Bubbles are not squeezed out; pipeline occupancy is at most SHAMT_W.
  - A result leaves on out_valid && out_ready; if adv = 1, the next entry shifts in on the same edge.
- Boundaries:
  - ctrl_shiftamt = 0 returns the operand unchanged in every mode.
  - The maximum shift (WIDTH-1) is legal:
    - SLL gives {LSB, zeros}.
    - SRL gives {zeros, MSB}.
    - SRA gives all copies of the MSB.
    - ROL gives {LSB, upper WIDTH-1 bits}.
  - ctrl_mode, ctrl_shiftamt and in_tag are sampled only on accept; changes while in_ready = 0 have no effect.
  - Simultaneous accept and drain with a full pipeline is legal and loses nothing.
- Reset:
  - All valid bits, all data, shamt, mode and tag registers go to 0 asynchronously.
  - Out of reset: out_valid = 0, shift_out = 0, out_tag = 0, in_ready = 1.
  - Reset asserted mid-operation discards all in-flight entries; none reappear after release.
  - Release is synchronous to clock; the first accept is possible on the first edge after release.

Test Plan (WIDTH=32, out_ready=1 unless stated):
- SLL 0x0000_0001, shamt 31, tag 3 -> shift_out 0x8000_0000, out_tag 3, exactly 5 cycles after accept.
- SRA 0x8000_00F0, shamt 4 -> 0xF800_000F. Same operand with SRL -> 0x0800_000F. ROL 0x8000_0001, shamt 1 -> 0x0000_0003.
- Back-to-back stream of 8 requests, shamt = i, SLL of 0x1 -> out_valid high for 8 consecutive cycles with results 1, 2, 4 ... 0x80 in order.
- Backpressure:
  - Stream 6 requests and hold out_ready = 0 from cycle 6.
  - Required: out_valid = 1, shift_out stable, in_ready = 0 (once full).
  - Release out_ready: all 6 results drain in order, none dropped or duplicated.
- shamt 0 in all four modes with 0xDEAD_BEEF -> 0xDEAD_BEEF each.
- Assert reset_n = 0 asynchronously with 3 entries in flight, release 2 cycles later -> out_valid = 0 immediately and stays 0 until a new accept; the new result appears after 5 cycles.
